// File: rtl/win_checker.sv
// Connect-four win detector: snapshots the board on start and scans one anchor
// cell per cycle for a four-in-a-row in H, V, DR and DL directions.
module win_checker #(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 7,
  parameter int unsigned WIN_LEN = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   gameboard,
  input  logic [ROWS*COLS-1:0]   players_cells,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             winner,
  output logic [ROWS*COLS-1:0]   win_cells,
  output logic                   draw
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned AW    = $clog2(NCELL);
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(COLS);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Window anchored at cell 0 (DL anchored at its top-right start column).
  function automatic logic [NCELL-1:0] line_mask(input int unsigned step,
                                                 input int unsigned offs);
    logic [NCELL-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < WIN_LEN; k++) begin
      m = m | (NCELL'(1) << (offs + k * step));
    end
    return m;
  endfunction

  localparam logic [NCELL-1:0] MASK_H  = line_mask(1, 0);
  localparam logic [NCELL-1:0] MASK_V  = line_mask(COLS, 0);
  localparam logic [NCELL-1:0] MASK_DR = line_mask(COLS + 1, 0);
  localparam logic [NCELL-1:0] MASK_DL = line_mask(COLS - 1, WIN_LEN - 1);

  function automatic logic window_wins(input logic [NCELL-1:0] m,
                                       input logic [NCELL-1:0] board,
                                       input logic [NCELL-1:0] owner);
    return ((board & m) == m) && (((owner & m) == m) || ((owner & m) == '0));
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state;
  logic [NCELL-1:0] r_board;
  logic [NCELL-1:0] r_owner;
  logic [AW-1:0]    r_anchor;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_winner;
  logic [NCELL-1:0] r_win_cells;
  logic             r_draw;

  state_t           w_state_nxt;
  logic [NCELL-1:0] w_board_nxt;
  logic [NCELL-1:0] w_owner_nxt;
  logic [AW-1:0]    w_anchor_nxt;
  logic [RW-1:0]    w_row_nxt;
  logic [CW-1:0]    w_col_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [1:0]       w_winner_nxt;
  logic [NCELL-1:0] w_win_cells_nxt;
  logic             w_draw_nxt;

  logic             w_fit_fwd;
  logic             w_fit_back;
  logic             w_fit_up;
  logic [NCELL-1:0] w_m_h;
  logic [NCELL-1:0] w_m_v;
  logic [NCELL-1:0] w_m_dr;
  logic [NCELL-1:0] w_m_dl;
  logic             w_win_h;
  logic             w_win_v;
  logic             w_win_dr;
  logic             w_win_dl;
  logic             w_hit;
  logic [NCELL-1:0] w_hit_mask;
  logic             w_hit_p2;

  // Window placement at the current anchor; DL shift underflows only when unfit.
  assign w_fit_fwd  = (r_col <= CW'(COLS - WIN_LEN));
  assign w_fit_back = (r_col >= CW'(WIN_LEN - 1));
  assign w_fit_up   = (r_row <= RW'(ROWS - WIN_LEN));

  assign w_m_h  = MASK_H  << r_anchor;
  assign w_m_v  = MASK_V  << r_anchor;
  assign w_m_dr = MASK_DR << r_anchor;
  assign w_m_dl = MASK_DL << (r_anchor - AW'(WIN_LEN - 1));

  assign w_win_h  = w_fit_fwd              && window_wins(w_m_h,  r_board, r_owner);
  assign w_win_v  = w_fit_up               && window_wins(w_m_v,  r_board, r_owner);
  assign w_win_dr = w_fit_fwd  && w_fit_up && window_wins(w_m_dr, r_board, r_owner);
  assign w_win_dl = w_fit_back && w_fit_up && window_wins(w_m_dl, r_board, r_owner);

  // Direction priority H > V > DR > DL.
  always_comb begin
    w_hit      = 1'b1;
    w_hit_mask = '0;
    if (w_win_h) begin
      w_hit_mask = w_m_h;
    end else if (w_win_v) begin
      w_hit_mask = w_m_v;
    end else if (w_win_dr) begin
      w_hit_mask = w_m_dr;
    end else if (w_win_dl) begin
      w_hit_mask = w_m_dl;
    end else begin
      w_hit = 1'b0;
    end
  end

  assign w_hit_p2 = |(r_owner & w_hit_mask);

  always_comb begin
    w_state_nxt     = r_state;
    w_board_nxt     = r_board;
    w_owner_nxt     = r_owner;
    w_anchor_nxt    = r_anchor;
    w_row_nxt       = r_row;
    w_col_nxt       = r_col;
    w_done_nxt      = 1'b0;
    w_winner_nxt    = r_winner;
    w_win_cells_nxt = r_win_cells;
    w_draw_nxt      = r_draw;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_board_nxt     = gameboard;
          w_owner_nxt     = players_cells & gameboard;
          w_winner_nxt    = WIN_NONE;
          w_win_cells_nxt = '0;
          w_draw_nxt      = 1'b0;
          w_anchor_nxt    = '0;
          w_row_nxt       = '0;
          w_col_nxt       = '0;
          w_state_nxt     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          w_winner_nxt    = w_hit_p2 ? WIN_P2 : WIN_P1;
          w_win_cells_nxt = w_hit_mask;
          w_draw_nxt      = 1'b0;
          w_state_nxt     = S_DONE;
        end else if (r_anchor == AW'(NCELL - 1)) begin
          w_draw_nxt  = &r_board;
          w_state_nxt = S_DONE;
        end else begin
          w_anchor_nxt = r_anchor + AW'(1);
          if (r_col == CW'(COLS - 1)) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + RW'(1);
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_board     <= '0;
      r_owner     <= '0;
      r_anchor    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_winner    <= WIN_NONE;
      r_win_cells <= '0;
      r_draw      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_board     <= w_board_nxt;
      r_owner     <= w_owner_nxt;
      r_anchor    <= w_anchor_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_winner    <= w_winner_nxt;
      r_win_cells <= w_win_cells_nxt;
      r_draw      <= w_draw_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign winner    = r_winner;
  assign win_cells = r_win_cells;
  assign draw      = r_draw;

endmodule
